branch_resolve_unit: RTL and testbench
======================================

// Module: branch_resolve_unit
// PURPOSE
//  Registered branch/jump resolution stage for the pipelined core, and the successor to the
//  combinational branch comparator. Resolves all six RV32I B-type conditions plus JAL/JALR,
//  computes target and link, and flags mispredictions against the fetch prediction.
//  Valid/ready handshake on both sides, one-entry output register, saturating mispredict counter.
// PARAMETERS
//  DWIDTH     32  operand / PC / immediate width
//  CNT_WIDTH  16  mispredict counter width
// PORTS
//  clk           in   1          clock, rising edge
//  reset_n       in   1          async reset, active-low
//  in_valid_i    in   1          request valid
//  in_ready_o    out  1          unit can accept request
//  opcode_i      in   7          instruction opcode
//  funct3_i      in   3          branch condition
//  pc_i          in   DWIDTH     instruction PC
//  imm_i         in   DWIDTH     sign-extended immediate
//  rs1_i         in   DWIDTH     rs1 data
//  rs2_i         in   DWIDTH     rs2 data
//  pred_taken_i  in   1          fetch predicted taken
//  pred_target_i in   DWIDTH     fetch predicted target
//  out_valid_o   out  1          result valid
//  out_ready_i   in   1          consumer accepts result
//  taken_o       out  1          branch/jump taken
//  next_pc_o     out  DWIDTH     resolved next PC
//  link_o        out  DWIDTH     pc+4 (JAL/JALR writeback value)
//  mispredict_o  out  1          prediction wrong, redirect to next_pc_o
//  illegal_o     out  1          B-type with funct3 010/011
//  flush_i       in   1          kill held result
//  cnt_clear_i   in   1          zero the mispredict counter
//  mispred_cnt_o out  CNT_WIDTH  saturating count of accepted mispredicts
// BEHAVIOUR
//  Reset (reset_n=0, async): out_valid_o=0, taken_o=0, next_pc_o=0, link_o=0, mispredict_o=0,
//   illegal_o=0, mispred_cnt_o=0. in_ready_o is combinational and is therefore 1 during reset.
//  in_ready_o = !flush_i && (!out_valid_o || out_ready_i); input accepted when in_valid_i && in_ready_o.
//  Latency: 1 cycle. Accept at edge N -> result on outputs after N, held stable until out handshake.
//  Result fields load only on accept; fields hold while out_valid_o=1 && out_ready_i=0.
//  Conditions (BTYPE 1100011): 000 eq, 001 ne, 100 signed lt, 101 signed ge, 110 unsigned lt,
//   111 unsigned ge; 010/011 -> taken=0, illegal=1.
//  JAL 1101111: taken=1, target=pc+imm. JALR 1100111: taken=1, target=(rs1+imm)&~1.
//  BTYPE target=pc+imm. All adds wrap modulo 2^DWIDTH. link=pc+4 for every opcode.
//  Any other opcode: taken=0, illegal=0 (pass-through, no control transfer).
//  next_pc = taken ? target : pc+4.
//  mispredict = (taken != pred_taken_i) || (taken && target != pred_target_i).
//  out_valid_o next: flush_i -> 0; else accept -> 1; else out_ready_i -> 0; else hold.
//  flush_i dominates: held result dropped, no new accept that cycle, counter not incremented.
//  Simultaneous out handshake and new accept: new result loads, out_valid_o stays 1 (no bubble).
//  Counter: +1 on out_valid_o && out_ready_i && mispredict_o && !flush_i; saturates at 2^CNT_WIDTH-1.
//  cnt_clear_i wins over a simultaneous increment (counter -> 0).
//  Reset asserted mid-transaction: held result discarded; no partial state survives.
// TESTING
//  BEQ rs1=rs2=5, pc=0x100, imm=0x20, pred_taken=0 -> taken=1, next_pc=0x120, mispredict=1, cnt=1.
//  BLT rs1=0xFFFFFFFF, rs2=1 -> taken=1; BLTU same operands -> taken=0, next_pc=pc+4.
//  JALR rs1=0x1001, imm=2, pred_target=0x1002, pred_taken=1 -> next_pc=0x1002, link=pc+4, mispredict=0.
//  out_ready_i=0 for 3 cycles -> in_ready_o=0, outputs stable; ready=1 with in_valid=1 -> back-to-back, no bubble.
//  flush_i with result held -> out_valid_o=0 next cycle, in_ready_o=0 that cycle, cnt unchanged.
//  CNT_WIDTH=2, 5 accepted mispredicts -> cnt=3; cnt_clear_i with concurrent mispredict -> cnt=0.

Source files
------------

// File: rtl/branch_resolve_unit.sv
// Registered branch/jump resolution stage: resolves RV32I B-type, JAL and JALR,
// flags mispredictions and holds one result behind a valid/ready handshake.
module branch_resolve_unit #(
    parameter int DWIDTH    = 32,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [6:0]           opcode_i,
    input  logic [2:0]           funct3_i,
    input  logic [DWIDTH-1:0]    pc_i,
    input  logic [DWIDTH-1:0]    imm_i,
    input  logic [DWIDTH-1:0]    rs1_i,
    input  logic [DWIDTH-1:0]    rs2_i,
    input  logic                 pred_taken_i,
    input  logic [DWIDTH-1:0]    pred_target_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic                 taken_o,
    output logic [DWIDTH-1:0]    next_pc_o,
    output logic [DWIDTH-1:0]    link_o,
    output logic                 mispredict_o,
    output logic                 illegal_o,
    input  logic                 flush_i,
    input  logic                 cnt_clear_i,
    output logic [CNT_WIDTH-1:0] mispred_cnt_o
);

    localparam logic [6:0]           OP_BRANCH = 7'b1100011;
    localparam logic [6:0]           OP_JAL    = 7'b1101111;
    localparam logic [6:0]           OP_JALR   = 7'b1100111;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = {CNT_WIDTH{1'b1}};
    localparam logic [DWIDTH-1:0]    PC_STEP   = {{(DWIDTH-3){1'b0}}, 3'b100};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic                 taken_s;
    logic                 illegal_s;
    logic [DWIDTH-1:0]    target_s;
    logic [DWIDTH-1:0]    pc_plus4_s;
    logic [DWIDTH-1:0]    br_target_s;
    logic [DWIDTH-1:0]    jalr_sum_s;
    logic [DWIDTH-1:0]    next_pc_s;
    logic                 mispred_s;
    logic                 eq_s;
    logic                 lt_s;
    logic                 ltu_s;
    logic                 accept_s;
    logic                 cnt_inc_s;

    logic                 valid_q,   valid_d;
    logic                 taken_q,   taken_d;
    logic [DWIDTH-1:0]    next_pc_q, next_pc_d;
    logic [DWIDTH-1:0]    link_q,    link_d;
    logic                 mispred_q, mispred_d;
    logic                 illegal_q, illegal_d;
    logic [CNT_WIDTH-1:0] cnt_q,     cnt_d;

    assign pc_plus4_s  = pc_i + PC_STEP;
    assign br_target_s = pc_i + imm_i;
    assign jalr_sum_s  = rs1_i + imm_i;
    assign eq_s        = (rs1_i == rs2_i);
    assign lt_s        = ($signed(rs1_i) < $signed(rs2_i));
    assign ltu_s       = (rs1_i < rs2_i);

    // Condition evaluation and target selection for the incoming request
    always_comb begin
        taken_s   = 1'b0;
        illegal_s = 1'b0;
        target_s  = br_target_s;
        case (opcode_i)
            OP_BRANCH: begin
                case (funct3_i)
                    3'b000:  taken_s = eq_s;
                    3'b001:  taken_s = !eq_s;
                    3'b100:  taken_s = lt_s;
                    3'b101:  taken_s = !lt_s;
                    3'b110:  taken_s = ltu_s;
                    3'b111:  taken_s = !ltu_s;
                    default: illegal_s = 1'b1;
                endcase
            end
            OP_JAL:  taken_s = 1'b1;
            OP_JALR: begin
                taken_s  = 1'b1;
                target_s = {jalr_sum_s[DWIDTH-1:1], 1'b0};
            end
            default: taken_s = 1'b0;
        endcase
    end

    assign next_pc_s = taken_s ? target_s : pc_plus4_s;
    assign mispred_s = (taken_s != pred_taken_i) || (taken_s && (target_s != pred_target_i));

    assign in_ready_o = !flush_i && (!valid_q || out_ready_i);
    assign accept_s   = in_valid_i && in_ready_o;
    // Count on the output handshake so a flushed result never contributes
    assign cnt_inc_s  = valid_q && out_ready_i && mispred_q && !flush_i;

    // Next-state for the result register and the mispredict counter
    always_comb begin
        valid_d   = valid_q;
        taken_d   = taken_q;
        next_pc_d = next_pc_q;
        link_d    = link_q;
        mispred_d = mispred_q;
        illegal_d = illegal_q;
        cnt_d     = cnt_q;

        if (flush_i) begin
            valid_d = 1'b0;
        end else if (accept_s) begin
            valid_d   = 1'b1;
            taken_d   = taken_s;
            next_pc_d = next_pc_s;
            link_d    = pc_plus4_s;
            mispred_d = mispred_s;
            illegal_d = illegal_s;
        end else if (out_ready_i) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end

        if (cnt_clear_i) begin
            cnt_d = {CNT_WIDTH{1'b0}};
        end else if (cnt_inc_s && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Result and counter state registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q   <= 1'b0;
            taken_q   <= 1'b0;
            next_pc_q <= {DWIDTH{1'b0}};
            link_q    <= {DWIDTH{1'b0}};
            mispred_q <= 1'b0;
            illegal_q <= 1'b0;
            cnt_q     <= {CNT_WIDTH{1'b0}};
        end else begin
            valid_q   <= valid_d;
            taken_q   <= taken_d;
            next_pc_q <= next_pc_d;
            link_q    <= link_d;
            mispred_q <= mispred_d;
            illegal_q <= illegal_d;
            cnt_q     <= cnt_d;
        end
    end

    assign out_valid_o   = valid_q;
    assign taken_o       = taken_q;
    assign next_pc_o     = next_pc_q;
    assign link_o        = link_q;
    assign mispredict_o  = mispred_q;
    assign illegal_o     = illegal_q;
    assign mispred_cnt_o = cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: random traffic compared every cycle against an
// architectural model, plus directed cases with hand-computed expectations.
module tb_branch_resolve_unit;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        in_valid_i = 1'b0;
    logic [6:0]  opcode_i = 7'd0;
    logic [2:0]  funct3_i = 3'd0;
    logic [31:0] pc_i = 32'd0, imm_i = 32'd0, rs1_i = 32'd0, rs2_i = 32'd0;
    logic        pred_taken_i = 1'b0;
    logic [31:0] pred_target_i = 32'd0;
    logic        out_ready_i = 1'b0;
    logic        flush_i = 1'b0;
    logic        cnt_clear_i = 1'b0;

    logic        in_ready_o, out_valid_o, taken_o, mispredict_o, illegal_o;
    logic [31:0] next_pc_o, link_o;
    logic [15:0] mispred_cnt_o;
    logic        in_ready2, out_valid2, taken2, mispredict2, illegal2;
    logic [31:0] next_pc2, link2;
    logic [1:0]  cnt2;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    branch_resolve_unit #(.DWIDTH(32), .CNT_WIDTH(16)) u_dut (
        .clk(clk), .reset_n(reset_n), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .opcode_i(opcode_i), .funct3_i(funct3_i), .pc_i(pc_i), .imm_i(imm_i),
        .rs1_i(rs1_i), .rs2_i(rs2_i), .pred_taken_i(pred_taken_i), .pred_target_i(pred_target_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .taken_o(taken_o),
        .next_pc_o(next_pc_o), .link_o(link_o), .mispredict_o(mispredict_o),
        .illegal_o(illegal_o), .flush_i(flush_i), .cnt_clear_i(cnt_clear_i),
        .mispred_cnt_o(mispred_cnt_o));

    branch_resolve_unit #(.DWIDTH(32), .CNT_WIDTH(2)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .in_valid_i(in_valid_i), .in_ready_o(in_ready2),
        .opcode_i(opcode_i), .funct3_i(funct3_i), .pc_i(pc_i), .imm_i(imm_i),
        .rs1_i(rs1_i), .rs2_i(rs2_i), .pred_taken_i(pred_taken_i), .pred_target_i(pred_target_i),
        .out_valid_o(out_valid2), .out_ready_i(out_ready_i), .taken_o(taken2),
        .next_pc_o(next_pc2), .link_o(link2), .mispredict_o(mispredict2),
        .illegal_o(illegal2), .flush_i(flush_i), .cnt_clear_i(cnt_clear_i),
        .mispred_cnt_o(cnt2));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural meaning of one instruction
    function automatic void ref_resolve(input logic [6:0] op, input logic [2:0] f3,
                                        input logic [31:0] pc, input logic [31:0] imm,
                                        input logic [31:0] a, input logic [31:0] b,
                                        output bit tk, output bit ill, output logic [31:0] tgt);
        tk  = 1'b0;
        ill = 1'b0;
        tgt = pc + imm;
        if (op == 7'h63) begin
            case (f3)
                3'd0: tk = (a == b);
                3'd1: tk = (a != b);
                3'd4: tk = ($signed(a) < $signed(b));
                3'd5: tk = ($signed(a) >= $signed(b));
                3'd6: tk = (a < b);
                3'd7: tk = (a >= b);
                default: ill = 1'b1;
            endcase
        end else if (op == 7'h6F) begin
            tk = 1'b1;
        end else if (op == 7'h67) begin
            tk  = 1'b1;
            tgt = (a + imm) & ~32'd1;
        end
    endfunction

    bit          r_tk, r_ill, m_ready;
    logic [31:0] r_tgt;
    bit          m_valid = 1'b0, m_taken = 1'b0, m_mis = 1'b0, m_ill = 1'b0;
    logic [31:0] m_npc = 32'd0, m_link = 32'd0;
    int          m_cnt16 = 0, m_cnt2 = 0;

    always_comb begin
        ref_resolve(opcode_i, funct3_i, pc_i, imm_i, rs1_i, rs2_i, r_tk, r_ill, r_tgt);
        m_ready = !flush_i && (!m_valid || out_ready_i);
    end

    // Reference model state
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_valid <= 1'b0; m_taken <= 1'b0; m_mis <= 1'b0; m_ill <= 1'b0;
            m_npc <= 32'd0; m_link <= 32'd0; m_cnt16 <= 0; m_cnt2 <= 0;
        end else begin
            if (in_valid_i && m_ready) begin
                m_valid <= 1'b1;
                m_taken <= r_tk;
                m_ill   <= r_ill;
                m_npc   <= r_tk ? r_tgt : pc_i + 32'd4;
                m_link  <= pc_i + 32'd4;
                m_mis   <= (r_tk != pred_taken_i) || (r_tk && r_tgt != pred_target_i);
            end else if (flush_i || out_ready_i) begin
                m_valid <= 1'b0;
            end
            if (cnt_clear_i) begin
                m_cnt16 <= 0;
                m_cnt2  <= 0;
            end else if (m_valid && out_ready_i && m_mis && !flush_i) begin
                if (m_cnt16 < 65535) m_cnt16 <= m_cnt16 + 1;
                if (m_cnt2 < 3) m_cnt2 <= m_cnt2 + 1;
            end
        end
    end

    // Every-cycle comparison against the model, away from the rising edge
    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_in_ready", {31'd0, in_ready_o}, {31'd0, m_ready});
            chk("m_out_valid", {31'd0, out_valid_o}, {31'd0, m_valid});
            chk("m_taken", {31'd0, taken_o}, {31'd0, m_taken});
            chk("m_next_pc", next_pc_o, m_npc);
            chk("m_link", link_o, m_link);
            chk("m_mispredict", {31'd0, mispredict_o}, {31'd0, m_mis});
            chk("m_illegal", {31'd0, illegal_o}, {31'd0, m_ill});
            chk("m_cnt16", {16'd0, mispred_cnt_o}, m_cnt16);
            chk("m_cnt2", {30'd0, cnt2}, m_cnt2);
            chk("m_valid2", {31'd0, out_valid2}, {31'd0, m_valid});
            chk("m_next_pc2", next_pc2, m_npc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] pc,
                          input logic [31:0] imm, input logic [31:0] a, input logic [31:0] b,
                          input logic pt, input logic [31:0] ptgt);
        opcode_i = op; funct3_i = f3; pc_i = pc; imm_i = imm;
        rs1_i = a; rs2_i = b; pred_taken_i = pt; pred_target_i = ptgt;
    endtask

    int exp_cnt;
    logic [6:0] ops [4];

    initial begin
        ops[0] = 7'h63; ops[1] = 7'h6F; ops[2] = 7'h67; ops[3] = 7'h13;
        #2 reset_n = 1'b0;
        chk_en = 1'b1;
        tick(); tick();
        chk("rst_out_valid", {31'd0, out_valid_o}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready_o}, 32'd1);
        chk("rst_next_pc", next_pc_o, 32'd0);
        chk("rst_cnt", {16'd0, mispred_cnt_o}, 32'd0);
        reset_n = 1'b1;
        tick();

        // BEQ taken, predicted not taken
        out_ready_i = 1'b1; in_valid_i = 1'b1;
        set_op(7'h63, 3'd0, 32'h100, 32'h20, 32'd5, 32'd5, 1'b0, 32'd0);
        tick();
        chk("beq_taken", {31'd0, taken_o}, 32'd1);
        chk("beq_next_pc", next_pc_o, 32'h120);
        chk("beq_mispredict", {31'd0, mispredict_o}, 32'd1);
        in_valid_i = 1'b0;
        tick();
        chk("beq_cnt", {16'd0, mispred_cnt_o}, 32'd1);

        // BLT then BLTU back-to-back on the same operands
        in_valid_i = 1'b1;
        set_op(7'h63, 3'd4, 32'h200, 32'h40, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0);
        tick();
        chk("blt_taken", {31'd0, taken_o}, 32'd1);
        chk("blt_next_pc", next_pc_o, 32'h240);
        set_op(7'h63, 3'd6, 32'h200, 32'h40, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0);
        tick();
        chk("bltu_taken", {31'd0, taken_o}, 32'd0);
        chk("bltu_next_pc", next_pc_o, 32'h204);

        // JALR clears bit 0 of the target
        set_op(7'h67, 3'd0, 32'h300, 32'd2, 32'h1001, 32'd0, 1'b1, 32'h1002);
        tick();
        chk("jalr_next_pc", next_pc_o, 32'h1002);
        chk("jalr_link", link_o, 32'h304);
        chk("jalr_mispredict", {31'd0, mispredict_o}, 32'd0);
        in_valid_i = 1'b0;
        tick();

        // Backpressure: result held for 3 cycles, then no-bubble reload
        out_ready_i = 1'b0; in_valid_i = 1'b1;
        set_op(7'h6F, 3'd0, 32'h400, 32'h10, 32'd0, 32'd0, 1'b1, 32'h410);
        tick();
        chk("jal_valid", {31'd0, out_valid_o}, 32'd1);
        set_op(7'h63, 3'd1, 32'h500, 32'd8, 32'd1, 32'd2, 1'b0, 32'd0);
        for (int i = 0; i < 3; i++) begin
            chk("stall_in_ready", {31'd0, in_ready_o}, 32'd0);
            chk("stall_next_pc", next_pc_o, 32'h410);
            tick();
        end
        out_ready_i = 1'b1;
        #1;
        chk("release_in_ready", {31'd0, in_ready_o}, 32'd1);
        tick();
        chk("b2b_valid", {31'd0, out_valid_o}, 32'd1);
        chk("b2b_next_pc", next_pc_o, 32'h508);

        // Flush of a held mispredicted result
        in_valid_i = 1'b0; out_ready_i = 1'b0;
        tick();
        flush_i = 1'b1; out_ready_i = 1'b1; in_valid_i = 1'b1;
        #1;
        chk("flush_in_ready", {31'd0, in_ready_o}, 32'd0);
        exp_cnt = m_cnt16;
        tick();
        chk("flush_valid", {31'd0, out_valid_o}, 32'd0);
        chk("flush_cnt", {16'd0, mispred_cnt_o}, exp_cnt);
        flush_i = 1'b0; in_valid_i = 1'b0;

        // Saturation of the 2-bit counter and clear priority
        cnt_clear_i = 1'b1;
        tick();
        cnt_clear_i = 1'b0;
        set_op(7'h63, 3'd0, 32'h600, 32'h8, 32'd1, 32'd2, 1'b1, 32'h608);
        for (int i = 0; i < 5; i++) begin
            in_valid_i = 1'b1;
            tick();
            in_valid_i = 1'b0;
            tick();
        end
        chk("sat_cnt2", {30'd0, cnt2}, 32'd3);
        chk("sat_cnt16", {16'd0, mispred_cnt_o}, 32'd5);
        in_valid_i = 1'b1;
        tick();
        in_valid_i = 1'b0; cnt_clear_i = 1'b1;
        tick();
        cnt_clear_i = 1'b0;
        chk("clear_cnt2", {30'd0, cnt2}, 32'd0);
        chk("clear_cnt16", {16'd0, mispred_cnt_o}, 32'd0);

        // Reset in the middle of a held transaction
        out_ready_i = 1'b0; in_valid_i = 1'b1;
        set_op(7'h6F, 3'd0, 32'h700, 32'h40, 32'd0, 32'd0, 1'b0, 32'd0);
        tick();
        chk("pre_rst_valid", {31'd0, out_valid_o}, 32'd1);
        in_valid_i = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", {31'd0, out_valid_o}, 32'd0);
        chk("mid_rst_next_pc", next_pc_o, 32'd0);
        chk("mid_rst_link", link_o, 32'd0);
        tick(); tick();
        reset_n = 1'b1;
        tick();
        chk("post_rst_taken", {31'd0, taken_o}, 32'd0);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] a, b, pc, imm, tgt;
            bit tk, ill;
            a   = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
            b   = ($urandom_range(0, 2) == 0) ? a : $urandom;
            pc  = {$urandom_range(0, 65535), 2'b00};
            imm = $urandom_range(0, 1) ? $urandom_range(0, 4095) : -$urandom_range(0, 4095);
            opcode_i = ($urandom_range(0, 9) == 0) ? 7'($urandom) : ops[$urandom_range(0, 3)];
            funct3_i = 3'($urandom);
            pc_i = pc; imm_i = imm; rs1_i = a; rs2_i = b;
            ref_resolve(opcode_i, funct3_i, pc, imm, a, b, tk, ill, tgt);
            pred_taken_i  = $urandom_range(0, 1);
            pred_target_i = $urandom_range(0, 1) ? tgt : $urandom;
            in_valid_i    = ($urandom_range(0, 9) < 7);
            out_ready_i   = ($urandom_range(0, 9) < 7);
            flush_i       = ($urandom_range(0, 19) == 0);
            cnt_clear_i   = ($urandom_range(0, 39) == 0);
            tick();
        end
        in_valid_i = 1'b0; flush_i = 1'b0; cnt_clear_i = 1'b0;
        tick();
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
